// File: rtl/exp_pkg.sv
// Shared types and constants for the Q26 e^x evaluator.
package exp_pkg;
  localparam int Q     = 26;
  localparam int W     = 32;
  localparam int SEG_W = 3;
  localparam int PW    = 2 * W;

  typedef logic signed [W-1:0]  q_t;
  typedef logic signed [PW-1:0] wide_t;
  typedef logic [SEG_W-1:0]     seg_t;
  typedef logic signed [7:0]    shamt_t;

  localparam q_t    LOG2E_Q = 32'h05C5_51D9;
  localparam q_t    Y_SAT   = 32'h7FFF_FFFF;
  localparam wide_t HALF_Q  = 64'sd1 <<< (Q - 1);
endpackage

// File: rtl/exp_unit_pipe_if.sv
// Stream-in / LUT / stream-out bundle for one exp lane.
interface exp_unit_pipe_if;
  import exp_pkg::*;

  logic in_valid;
  logic in_ready;
  q_t   x_in;
  seg_t lut_seg_idx;
  q_t   lut_k;
  q_t   lut_b;
  logic out_valid;
  logic out_ready;
  q_t   y_out;

  modport slave (
    input  in_valid, x_in, lut_k, lut_b, out_ready,
    output in_ready, lut_seg_idx, out_valid, y_out
  );

  modport master (
    output in_valid, x_in, lut_k, lut_b, out_ready,
    input  in_ready, lut_seg_idx, out_valid, y_out
  );
endinterface

// File: rtl/exp_range_reduce.sv
// Combinational range reduction x*log2(e) -> 2^u * 2^v, 0 <= v < 1.
// EXP_UNIT_ROUND_EN selects round-half-up on the Q shift instead of floor.
module exp_range_reduce
  import exp_pkg::*;
(
  input  q_t     x,
  output shamt_t u,
  output q_t     v
);

  function automatic wide_t shr_q(input wide_t a);
`ifdef EXP_UNIT_ROUND_EN
    return (a + HALF_Q) >>> Q;
`else
    return a >>> Q;
`endif
  endfunction

  wide_t x_ext, c_ext, prod, z, u_full;

  assign x_ext  = x;
  assign c_ext  = LOG2E_Q;
  assign prod   = x_ext * c_ext;
  assign z      = shr_q(prod);
  assign u_full = z >>> Q;
  // Floor split: the low Q bits of z are exactly z - (u << Q).
  assign v      = {{(W-Q){1'b0}}, z[Q-1:0]};

  always_comb begin
    u = u_full[7:0];
    if (u_full > 64'sd127)
      u = 8'sd127;
    else if (u_full < -64'sd127)
      u = -8'sd127;
  end

endmodule

// File: rtl/exp_unit_pipe.sv
// Three-stage streaming e^x lane: range reduce, LUT linear 2^v, shift by u.
// EXP_UNIT_ROUND_EN enables round-half-up in both Q shifts and the final right shift.
module exp_unit_pipe
  import exp_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  exp_unit_pipe_if.slave  io
);

  function automatic wide_t shr_q(input wide_t a);
`ifdef EXP_UNIT_ROUND_EN
    return (a + HALF_Q) >>> Q;
`else
    return a >>> Q;
`endif
  endfunction

  // Applies 2^u to p; left shifts saturate, right shifts are logical.
  function automatic q_t scale(input q_t p, input shamt_t u);
    logic [PW-1:0] wide;
    logic [7:0]    s;
    logic [W:0]    pr;
    wide  = '0;
    s     = '0;
    pr    = '0;
    scale = '0;
    if (!u[7]) begin
      if (u > shamt_t'(W - 1)) begin
        scale = (p == '0) ? q_t'(0) : Y_SAT;
      end else begin
        wide  = {{W{1'b0}}, p} << u[4:0];
        scale = (wide[PW-1:W-1] != '0) ? Y_SAT : q_t'(wide[W-1:0]);
      end
    end else begin
      s = -u;
      if (s >= 8'(W)) begin
        scale = '0;
      end else begin
`ifdef EXP_UNIT_ROUND_EN
        pr = ({1'b0, p} + ((W+1)'(1) << (s[4:0] - 5'd1))) >> s[4:0];
`else
        pr = {1'b0, p} >> s[4:0];
`endif
        scale = pr[W] ? Y_SAT : q_t'(pr[W-1:0]);
      end
    end
  endfunction

  logic   en;
  logic   vld_p1, vld_p2, vld_p3;
  shamt_t u_s1, u_p1, u_p2;
  q_t     v_s1, v_p1;
  q_t     p_s2, p_p2;
  q_t     y_s3, y_p3;
  wide_t  k_ext, v_ext;

  assign en             = !vld_p3 || io.out_ready;
  assign io.in_ready    = en;
  assign io.out_valid   = vld_p3;
  assign io.y_out       = y_p3;
  assign io.lut_seg_idx = v_p1[Q-1 -: SEG_W];

  // S1: range reduction
  exp_range_reduce u_rr (
    .x (io.x_in),
    .u (u_s1),
    .v (v_s1)
  );

  // S2: 2^v ~= k*v + b from the shared LUT
  assign k_ext = io.lut_k;
  assign v_ext = v_p1;
  assign p_s2  = q_t'(shr_q(k_ext * v_ext)) + io.lut_b;

  // S3: scale by 2^u
  assign y_s3 = scale(p_p2, u_p2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      v_p1   <= '0;
      y_p3   <= '0;
    end else if (en) begin
      vld_p1 <= io.in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      v_p1   <= v_s1;
      y_p3   <= y_s3;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      u_p1 <= u_s1;
      u_p2 <= u_p1;
      p_p2 <= p_s2;
    end
  end

endmodule

// File: tb/tb_exp_unit_pipe.sv
// Scoreboard bench for exp_unit_pipe with a chord-fit 8-segment 2^v LUT.
module tb_exp_unit_pipe;
  import exp_pkg::*;

  typedef struct {
    logic [31:0] expv;
    int          tol;
    int          tag;
  } exp_t;

  localparam real ONE = 67108864.0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic toggle = 1'b0;
  int   nchk = 0;
  int   nerr = 0;
  exp_t sb[$];
  q_t   k_tab [8];
  q_t   b_tab [8];

  exp_unit_pipe_if dut_if ();

  exp_unit_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (dut_if.slave)
  );

  always #5 clk = ~clk;

  assign dut_if.lut_k = k_tab[dut_if.lut_seg_idx];
  assign dut_if.lut_b = b_tab[dut_if.lut_seg_idx];

  // Chord of 2^v per segment, lowered by half its peak error (segment 0 keeps b = 1.0).
  initial begin
    for (int i = 0; i < 8; i++) begin
      real a, fa, fb, k, b;
      a  = i / 8.0;
      fa = $exp(a * 0.6931471805599453);
      fb = $exp(((i + 1) / 8.0) * 0.6931471805599453);
      k  = (fb - fa) * 8.0;
      b  = fa - k * a;
      if (i != 0) b = b - 0.5 * (1.0 / 512.0) * 0.480453 * fb;
      k_tab[i] = $rtoi(k * ONE + 0.5);
      b_tab[i] = $rtoi(b * ONE + 0.5);
    end
  end

  initial begin
    dut_if.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      dut_if.out_ready = toggle ? ~dut_if.out_ready : 1'b1;
    end
  end

  function automatic void model(input int xi, input int tol_ovr,
                                output logic [31:0] expv, output int tol);
    real ideal;
    ideal = $exp(real'(xi) / ONE) * ONE;
    if (ideal >= 2147483647.0) expv = 32'h7FFF_FFFF;
    else                       expv = 32'($rtoi(ideal + 0.5));
    if (tol_ovr >= 0)       tol = tol_ovr;
    else if (ideal > 2.2e9) tol = 0;
    else                    tol = $rtoi(ideal * 0.002) + 3;
  endfunction

  // Monitor: handshake rule every cycle, scoreboard pop on each output transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      nchk++;
      if (dut_if.in_ready !== (!dut_if.out_valid || dut_if.out_ready)) begin
        nerr++;
        $display("FAIL in_ready got=%b want=%b", dut_if.in_ready,
                 (!dut_if.out_valid || dut_if.out_ready));
      end
      if (dut_if.out_valid && dut_if.out_ready) begin
        nchk++;
        if (sb.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_output got=%h want=none", dut_if.y_out);
        end else begin
          exp_t   e;
          longint d;
          e = sb.pop_front();
          d = longint'($unsigned(dut_if.y_out)) - longint'(e.expv);
          if (d < 0) d = -d;
          if (d > longint'(e.tol)) begin
            nerr++;
            $display("FAIL y_out tag=%0d got=%h want=%h tol=%0d", e.tag,
                     dut_if.y_out, e.expv, e.tol);
          end
        end
      end
    end
  end

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Leaves in_valid high so consecutive calls stream one sample per cycle.
  task automatic send_one(input int xi, input int tol_ovr, input int tag);
    logic [31:0] ev;
    int          tl;
    int          n;
    n = 0;
    dut_if.in_valid = 1'b1;
    dut_if.x_in     = xi;
    @(negedge clk);
    while (!dut_if.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!dut_if.in_ready) begin
      nchk++;
      nerr++;
      $display("FAIL accept_timeout tag=%0d got=stalled want=accepted", tag);
    end else begin
      model(xi, tol_ovr, ev, tl);
      sb.push_back('{ev, tl, tag});
    end
    @(posedge clk); #1;
  endtask

  task automatic check_lat(input int xi, input int tol_ovr, input int seg, input int tag);
    int n;
    send_one(xi, tol_ovr, tag);
    dut_if.in_valid = 1'b0;
    check_eq($sformatf("seg_idx_%0d", tag), 32'(dut_if.lut_seg_idx), 32'(seg));
    n = 1;
    while (!dut_if.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq($sformatf("latency_%0d", tag), 32'(n), 32'd3);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    real burst [8];
    int  t0;
    burst = '{-3.0, -2.0, -1.0, -0.5, 0.0, 0.5, 1.0, 2.0};
    dut_if.in_valid = 1'b0;
    dut_if.x_in     = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(dut_if.out_valid), 32'd0);
    check_eq("rst_y_out", dut_if.y_out, 32'd0);
    check_eq("rst_seg_idx", 32'(dut_if.lut_seg_idx), 32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", 32'(dut_if.in_ready), 32'd1);

    check_lat(32'h0000_0000, 0, 0, 1);
    check_lat(32'hFC00_0000, 65536, 4, 2);
    check_lat(32'h0400_0000, 134218, 3, 3);
    check_lat(30 * 67108864, -1, 2, 4);
    check_lat(-20 * 67108864, 0, 1, 5);

    t0 = int'($time);
    for (int i = 0; i < 8; i++) send_one($rtoi(burst[i] * ONE), -1, 10 + i);
    dut_if.in_valid = 1'b0;
    check_eq("burst_cycles", 32'(int'($time) - t0), 32'd80);
    drain("drain_burst");

    toggle = 1'b1;
    for (int i = 0; i < 8; i++) send_one($rtoi(burst[i] * ONE), -1, 20 + i);
    dut_if.in_valid = 1'b0;
    drain("drain_stall_burst");
    toggle = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send_one(32'h0200_0000, -1, 30);
    send_one(32'h0400_0000, -1, 31);
    send_one(32'h0600_0000, -1, 32);
    dut_if.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(dut_if.out_valid), 32'd0);
    check_eq("midrst_y_out", dut_if.y_out, 32'd0);
    check_eq("midrst_seg_idx", 32'(dut_if.lut_seg_idx), 32'd0);
    sb.delete();
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_lat(32'h0000_0000, 0, 0, 33);

    for (int i = 0; i < 24; i++)
      send_one(int'($urandom_range(1342177280, 0)) - 1073741824, -1, 40 + i);
    dut_if.in_valid = 1'b0;
    drain("drain_random");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
